axilite_mem_agent: RTL

AXI4-Lite responder backed by a byte-writable on-chip memory. It is the subordinate end of the AXI4-Lite link that `umi2axilite` drives. Benches use it to close a UMI→AXI4-Lite path without the `axilite2umi` + `umi_mem_agent` round trip, so AXI-side behaviour can be checked in isolation. Writes and reads are served independently, with one outstanding transaction per direction.

---
 rtl/axilite_mem_agent.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/axilite_mem_agent.sv
// AXI4-Lite subordinate backed by a byte-writable word memory.
// One outstanding write and one outstanding read, served independently.
module axilite_mem_agent #(
    parameter int unsigned AW    = 64,
    parameter int unsigned DW    = 64,
    parameter int unsigned DEPTH = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AW-1:0]     axi_awaddr,
    input  logic [2:0]        axi_awprot,
    input  logic              axi_awvalid,
    output logic              axi_awready,
    input  logic [DW-1:0]     axi_wdata,
    input  logic [DW/8-1:0]   axi_wstrb,
    input  logic              axi_wvalid,
    output logic              axi_wready,
    output logic [1:0]        axi_bresp,
    output logic              axi_bvalid,
    input  logic              axi_bready,
    input  logic [AW-1:0]     axi_araddr,
    input  logic [2:0]        axi_arprot,
    input  logic              axi_arvalid,
    output logic              axi_arready,
    output logic [DW-1:0]     axi_rdata,
    output logic [1:0]        axi_rresp,
    output logic              axi_rvalid,
    input  logic              axi_rready
);

    localparam int unsigned SW  = DW / 8;
    localparam int unsigned OFS = $clog2(SW);
    localparam int unsigned IW  = $clog2(DEPTH);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic          aw_full_q, aw_full_d;
    logic [AW-1:0] aw_addr_q, aw_addr_d;
    logic          w_full_q,  w_full_d;
    logic [DW-1:0] w_data_q,  w_data_d;
    logic [SW-1:0] w_strb_q,  w_strb_d;
    logic          bvalid_q,  bvalid_d;
    logic [1:0]    bresp_q,   bresp_d;
    logic          rvalid_q,  rvalid_d;
    logic [1:0]    rresp_q,   rresp_d;
    logic [DW-1:0] rdata_q,   rdata_d;

    logic [DW-1:0] mem [DEPTH];

    logic          aw_hs, w_hs, ar_hs, wr_fire;
    logic          wr_ok, rd_ok;
    logic [IW-1:0] wr_idx, rd_idx;
    logic          unused_c;

    function automatic logic in_range(input logic [AW-1:0] a);
        return (a >> (OFS + IW)) == '0;
    endfunction

    assign unused_c = ^{axi_awprot, axi_arprot, aw_addr_q[OFS-1:0], axi_araddr[OFS-1:0]};

    assign axi_awready = !reset && !aw_full_q;
    assign axi_wready  = !reset && !w_full_q;
    assign axi_arready = !reset && (!rvalid_q || axi_rready);

    assign aw_hs   = axi_awvalid && axi_awready;
    assign w_hs    = axi_wvalid && axi_wready;
    assign ar_hs   = axi_arvalid && axi_arready;
    // Fire only when the B slot is empty or being drained this cycle.
    assign wr_fire = !reset && aw_full_q && w_full_q && (!bvalid_q || axi_bready);

    assign wr_idx = aw_addr_q[OFS +: IW];
    assign wr_ok  = in_range(aw_addr_q);
    assign rd_idx = axi_araddr[OFS +: IW];
    assign rd_ok  = in_range(axi_araddr);

    assign axi_bvalid = bvalid_q;
    assign axi_bresp  = bresp_q;
    assign axi_rvalid = rvalid_q;
    assign axi_rresp  = rresp_q;
    assign axi_rdata  = rdata_q;

    // Next-state for holding registers and response channels.
    always_comb begin
        aw_full_d = aw_full_q;
        aw_addr_d = aw_addr_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;

        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_addr_d = axi_awaddr;
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            w_data_d = axi_wdata;
            w_strb_d = axi_wstrb;
        end

        if (wr_fire) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = wr_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (bvalid_q && axi_bready) begin
            bvalid_d = 1'b0;
        end

        // Memory array still holds pre-write data during a colliding write.
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rresp_d  = rd_ok ? RESP_OKAY : RESP_SLVERR;
            rdata_d  = rd_ok ? mem[rd_idx] : '0;
        end else if (rvalid_q && axi_rready) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            aw_full_q <= 1'b0;
            aw_addr_q <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            rvalid_q  <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
        end else begin
            aw_full_q <= aw_full_d;
            aw_addr_q <= aw_addr_d;
            w_full_q  <= w_full_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

    // Memory contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_fire && wr_ok) begin
            for (int i = 0; i < int'(SW); i++) begin
                if (w_strb_q[i]) begin
                    mem[wr_idx][8*i +: 8] <= w_data_q[8*i +: 8];
                end
            end
        end
    end

endmodule
